fetch_unit: RTL and testbench

//  Initiator side of the instruction-ROM interface. Holds the program counter and issues

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } Signals;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, insn, fault} entries; flush beats push.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one outstanding ROM read, fault tagging and decode buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          ROM_WORDS = 128,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output Signals      o_rom_signals,
    input  Signals      i_rom_signals,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output Signals      o_signals,
    output logic        o_fetch_fault
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic          infl_q, infl_d;
    logic [31:0]   infl_pc_q, infl_pc_d;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          head_valid, push, pop, issue, infl_fault;
    logic [31:0]   redirect_pc, occupancy;
    logic          unused_inputs;

    assign unused_inputs = ^{i_rom_signals.pc, i_redirect_pc[1:0]};
    assign redirect_pc   = align_word(i_redirect_pc);
    assign infl_fault    = infl_pc_q[31:2] >= 30'(ROM_WORDS);

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        head_valid = fifo_count != '0;
        o_valid    = head_valid && !i_redirect;
        pop        = o_valid && i_ready;
        push       = infl_q && !i_redirect;
        occupancy  = 32'(fifo_count) + 32'(infl_q) - 32'(pop);
        issue      = occupancy < 32'(BUF_DEPTH);

        push_entry.pc    = infl_pc_q;
        push_entry.insn  = infl_fault ? NOP_INSN : i_rom_signals.insn;
        push_entry.fault = infl_fault;

        pc_d               = pc_q;
        infl_d             = 1'b0;
        infl_pc_d          = infl_pc_q;
        o_rom_signals.pc   = pc_q;
        o_rom_signals.insn = '0;
        if (i_redirect) begin
            o_rom_signals.pc = redirect_pc;
            infl_d           = 1'b1;
            infl_pc_d        = redirect_pc;
            pc_d             = redirect_pc + 32'd4;
        end else if (issue) begin
            infl_d    = 1'b1;
            infl_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
        end

        o_signals.pc   = head_valid ? fifo_head.pc   : '0;
        o_signals.insn = head_valid ? fifo_head.insn : '0;
        o_fetch_fault  = head_valid && fifo_head.fault;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (i_redirect),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases, a redirect table and random traffic.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int          ROM_WORDS = 128;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    Signals      o_rom_signals, i_rom_signals, o_signals;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_valid, i_ready = 1'b1, o_fetch_fault;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .ROM_WORDS(ROM_WORDS), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_rom_signals (o_rom_signals),
        .i_rom_signals (i_rom_signals),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_signals     (o_signals),
        .o_fetch_fault (o_fetch_fault)
    );

    always #5 clk = ~clk;

    // ROM image and its 1-cycle registered read port; out-of-range reads return junk.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return (idx * 32'h0101_0101) ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic exp_fault(input logic [31:0] pc);
        return (pc >> 2) >= 32'(ROM_WORDS);
    endfunction

    function automatic logic [31:0] exp_insn(input logic [31:0] pc);
        return exp_fault(pc) ? NOP_INSN : rom_word(pc >> 2);
    endfunction

    always @(posedge clk) begin
        i_rom_signals.pc   <= o_rom_signals.pc;
        i_rom_signals.insn <= exp_fault(o_rom_signals.pc) ? 32'hDEAD_BEEF
                                                          : rom_word(o_rom_signals.pc >> 2);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: the accepted stream is a run of consecutive PCs starting at the
    // reset PC or the latest aligned redirect target.
    logic [31:0] exp_pc = RESET_PC;
    int          n_xfer = 0;
    logic        hold_prev = 1'b0;
    Signals      held;
    logic        s_valid, s_fault;
    Signals      s_sig;
    logic [31:0] s_rom_pc;

    task automatic cycle(input logic ready, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        i_ready       = ready;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        @(negedge clk);
        s_valid  = o_valid;
        s_sig    = o_signals;
        s_fault  = o_fetch_fault;
        s_rom_pc = o_rom_signals.pc;
        if (redir) begin
            check("redirect_valid", 32'(s_valid), 32'd0);
            check("redirect_rom_pc", s_rom_pc, {rpc[31:2], 2'b00});
            exp_pc = {rpc[31:2], 2'b00};
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(s_valid), 32'd1);
                check("hold_pc", s_sig.pc, held.pc);
                check("hold_insn", s_sig.insn, held.insn);
            end
            if (s_valid && ready) begin
                check("xfer_pc", s_sig.pc, exp_pc);
                check("xfer_insn", s_sig.insn, exp_insn(exp_pc));
                check("xfer_fault", 32'(s_fault), 32'(exp_fault(exp_pc)));
                exp_pc += 32'd4;
                n_xfer++;
            end
        end
        hold_prev = s_valid && !ready && !redir;
        held      = s_sig;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_fault"}, 32'(o_fetch_fault), 32'd0);
        check({tag, "_sig_pc"}, o_signals.pc, 32'd0);
        check({tag, "_sig_insn"}, o_signals.insn, 32'd0);
        check({tag, "_rom_pc"}, o_rom_signals.pc, RESET_PC);
    endtask

    task automatic release_and_measure(input string tag);
        int first = 0;
        @(posedge clk);
        #1;
        i_ready    = 1'b1;
        i_redirect = 1'b0;
        rst_n      = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (s_valid && first == 0) first = k;
        end
        check({tag, "_first_valid_cycle"}, 32'(first), 32'd2);
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fault;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          base;
        logic [31:0] frozen;

        vecs[0] = '{rpc: 32'h0000_0043, pc: 32'h0000_0040, insn: rom_word(32'd16),  fault: 1'b0};
        vecs[1] = '{rpc: 32'h0000_01FC, pc: 32'h0000_01FC, insn: rom_word(32'd127), fault: 1'b0};
        vecs[2] = '{rpc: 32'h0000_0200, pc: 32'h0000_0200, insn: NOP_INSN,          fault: 1'b1};
        vecs[3] = '{rpc: 32'hFFFF_FFFE, pc: 32'hFFFF_FFFC, insn: NOP_INSN,          fault: 1'b1};
        vecs[4] = '{rpc: 32'h0000_0001, pc: 32'h0000_0000, insn: rom_word(32'd0),   fault: 1'b0};
        vecs[5] = '{rpc: 32'h0000_0105, pc: 32'h0000_0104, insn: rom_word(32'd65),  fault: 1'b0};

        // Reset values, then first valid two cycles after release with a gapless stream.
        #1;
        check_reset_outputs("reset");
        release_and_measure("start");
        base = n_xfer;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, '0);
        check("stream_one_per_cycle", 32'(n_xfer - base), 32'd6);

        // Stall: buffer fills to BUF_DEPTH, PC freezes, head holds; then resumes gaplessly.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, '0);
            if (k == 8) frozen = s_rom_pc;
        end
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_rom_pc_frozen", s_rom_pc, frozen);
        check("stall_buffered_depth", s_rom_pc, s_sig.pc + 32'(4 * BUF_DEPTH));
        base = n_xfer;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, '0);
        check("resume_one_per_cycle", 32'(n_xfer - base), 32'd6);

        // Redirect with a read in flight, then again with the buffer full.
        cycle(1'b0, 1'b1, 32'h0000_0040);
        cycle(1'b1, 1'b0, '0);
        check("redir1_gap_valid", 32'(s_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("redir1_first_valid", 32'(s_valid), 32'd1);
        check("redir1_first_pc", s_sig.pc, 32'h0000_0040);
        cycle(1'b1, 1'b0, '0);
        check("redir1_second_pc", s_sig.pc, 32'h0000_0044);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0080);
        cycle(1'b1, 1'b0, '0);
        check("redir2_gap_valid", 32'(s_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("redir2_first_pc", s_sig.pc, 32'h0000_0080);

        // Redirect table: alignment, last ROM word, out-of-range fault and PC wrap.
        foreach (vecs[i]) begin
            cycle(1'b1, 1'b1, vecs[i].rpc);
            cycle(1'b1, 1'b0, '0);
            cycle(1'b1, 1'b0, '0);
            check("vec_valid", 32'(s_valid), 32'd1);
            check("vec_pc", s_sig.pc, vecs[i].pc);
            check("vec_insn", s_sig.insn, vecs[i].insn);
            check("vec_fault", 32'(s_fault), 32'(vecs[i].fault));
            for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0);
        end

        // Random back-pressure and redirects, checked against the stream model.
        for (int k = 0; k < 400; k++) begin
            logic        rdy, rd;
            logic [31:0] tgt;
            rdy = $urandom_range(0, 3) != 0;
            rd  = $urandom_range(0, 19) == 0;
            tgt = $urandom_range(0, 32'h27F);
            cycle(rdy, rd, tgt);
        end
        check("random_made_progress", 32'(n_xfer > 200), 32'd1);

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, '0);
        check("pre_reset_valid", 32'(s_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_pc    = RESET_PC;
        hold_prev = 1'b0;
        repeat (2) @(posedge clk);
        release_and_measure("restart");
        check("restart_pc_seq", exp_pc, RESET_PC + 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
